// File: rtl/snn_spike_rate_decoder_if.sv
// snn_spike_rate_decoder_if: spike/enable inputs and the rate/ISI result handshake
interface snn_spike_rate_decoder_if #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             en;
  logic             spike_in;
  logic             out_ready;
  logic             out_valid;
  logic [CNT_W-1:0] rate_out;
  logic [ISI_W-1:0] isi_out;
  logic             overrun;
  modport master (output en, spike_in, out_ready, input out_valid, rate_out, isi_out, overrun);
  modport slave  (input en, spike_in, out_ready, output out_valid, rate_out, isi_out, overrun);
endinterface

// File: rtl/snn_spike_rate_decoder.sv
// snn_spike_rate_decoder: per-window spike count and minimum inter-spike interval with a 1-entry output buffer
module snn_spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 6,
  parameter int CNT_W       = 8,
  parameter int ISI_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  snn_spike_rate_decoder_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t                 state_q, state_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [CNT_W-1:0]       spk_q, spk_d, cnt_new, rate_q, rate_d;
  logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d, min_q, min_d, min_new, isi_q, isi_d;
  logic                   seen_q, seen_d, valid_q, valid_d, ovr_q, ovr_d;
  logic                   leave, spike, close, load;
  // en high makes the current cycle an ACCUM cycle; dropping en discards the partial window
  always_comb begin
    state_d   = bus.en ? ACCUM : IDLE;
    leave     = state_q == ACCUM && !bus.en;
    spike     = bus.en && bus.spike_in;
    close     = bus.en && win_q == '1;
    cnt_new   = (spike && ~&spk_q) ? spk_q + CNT_W'(1) : spk_q;
    min_new   = (spike && seen_q && isi_cnt_q < min_q) ? isi_cnt_q : min_q;
    win_d     = leave ? '0 : win_q + WINDOW_LOG2'(bus.en);
    spk_d     = (close || leave) ? '0 : cnt_new;
    min_d     = (close || leave) ? '1 : min_new;
    isi_cnt_d = spike ? ISI_W'(1) : (bus.en && ~&isi_cnt_q) ? isi_cnt_q + ISI_W'(1) : isi_cnt_q;
    seen_d    = !leave && (seen_q || spike);
    load      = close && (!valid_q || bus.out_ready);
    valid_d   = load || (valid_q && !bus.out_ready);
    rate_d    = load ? cnt_new : rate_q;
    isi_d     = load ? min_new : isi_q;
    ovr_d     = ovr_q || (close && valid_q && !bus.out_ready);
  end
  // state, window accumulators and output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      spk_q     <= '0;
      isi_cnt_q <= '0;
      min_q     <= '1;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      rate_q    <= '0;
      isi_q     <= '1;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      spk_q     <= spk_d;
      isi_cnt_q <= isi_cnt_d;
      min_q     <= min_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      rate_q    <= rate_d;
      isi_q     <= isi_d;
      ovr_q     <= ovr_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.rate_out  = rate_q;
  assign bus.isi_out   = isi_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_snn_spike_rate_decoder.sv
// tb_snn_spike_rate_decoder: random stimulus, window-level reference model and scoreboard
module tb_snn_spike_rate_decoder;
  localparam int W = 64;
  typedef struct {int cnt; int isi;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  snn_spike_rate_decoder_if #(.CNT_W(8), .ISI_W(8)) b8 ();
  snn_spike_rate_decoder_if #(.CNT_W(4), .ISI_W(8)) b4 ();
  snn_spike_rate_decoder #(.WINDOW_LOG2(6), .CNT_W(8), .ISI_W(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  snn_spike_rate_decoder #(.WINDOW_LOG2(6), .CNT_W(4), .ISI_W(8)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  assign b4.en        = b8.en;
  assign b4.spike_in  = b8.spike_in;
  assign b4.out_ready = b8.out_ready;
  always #5 clk = ~clk;
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  bit   done   = 0;
  int   t_en   = 0;
  int   prev   = -1;
  int   win[$];
  res_t exp_q[$];
  bit   m_valid = 0;
  bit   m_ovr   = 0;
  bit   a_rst, a_en, a_sp, a_rdy;
  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction
  // reference: windows of 64 enabled cycles, spike times kept as absolute enabled-cycle indices
  task automatic step();
    int   p, mn;
    bit   close;
    res_t r;
    close = 0;
    if (a_rst) begin
      t_en = 0; prev = -1; win.delete(); m_valid = 0; m_ovr = 0; exp_q.delete();
      return;
    end
    if (!a_en) begin
      t_en = 0; prev = -1; win.delete();
    end else begin
      if (a_sp) win.push_back(t_en);
      close = (t_en % W) == W - 1;
      if (close) begin
        p = prev; mn = 255;
        foreach (win[k]) begin
          if (p >= 0) mn = (win[k] - p < mn) ? win[k] - p : mn;
          p = win[k];
        end
        prev = p;
        r.cnt = win.size(); r.isi = mn;
        win.delete();
      end
      t_en++;
    end
    if (close && (!m_valid || a_rdy)) begin
      exp_q.push_back(r);
      m_valid = 1;
    end else if (close) m_ovr = 1;
    else if (m_valid && a_rdy) m_valid = 0;
  endtask
  task automatic apply(bit r, bit e, bit s, bit rd);
    rst = r; b8.en = e; b8.spike_in = s; b8.out_ready = rd;
    a_rst = r; a_en = e; a_sp = s; a_rdy = rd;
    @(posedge clk);
    #1;
    step();
    if (r) begin
      chk("reset_rate", int'(b8.rate_out), 0);
      chk("reset_isi", int'(b8.isi_out), 255);
      chk("reset_valid", int'(b8.out_valid), 0);
      chk("reset_overrun", int'(b8.overrun), 0);
    end
  endtask
  // en_m: 0/1 fixed, 2 mostly on; sp_m: 0 none, 1 every 4th, 2 always, 3 p=1/4, 4 p=1/16; rd_m: 0,1, 2 random, 3 only on close
  task automatic run(int n, int en_m, int sp_m, int rd_m);
    bit e, s, rd;
    for (int i = 0; i < n; i++) begin
      e  = (en_m == 2) ? ($urandom_range(0, 199) != 0) : en_m[0];
      s  = (sp_m == 1) ? (i % 4 == 0) : (sp_m == 2) ? 1'b1 :
           (sp_m == 3) ? ($urandom_range(0, 3) == 0) : (sp_m == 4) ? ($urandom_range(0, 15) == 0) : 1'b0;
      rd = (rd_m == 2) ? ($urandom_range(0, 2) != 0) : (rd_m == 3) ? (e && (t_en % W) == W - 1) : rd_m[0];
      apply(1'b0, e, s, rd);
    end
  endtask
  // monitor: compare buffer flags every cycle, pop and compare on each transfer
  always @(negedge clk) begin
    res_t r;
    if (!done) begin
      chk("out_valid", int'(b8.out_valid), int'(m_valid));
      chk("out_valid_c4", int'(b4.out_valid), int'(m_valid));
      chk("overrun", int'(b8.overrun), int'(m_ovr));
      if (b8.out_valid && b8.out_ready && !rst) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r = exp_q.pop_front();
          pops++;
          chk("rate_out", int'(b8.rate_out), r.cnt > 255 ? 255 : r.cnt);
          chk("isi_out", int'(b8.isi_out), r.isi);
          chk("rate_out_c4", int'(b4.rate_out), r.cnt > 15 ? 15 : r.cnt);
          chk("isi_out_c4", int'(b4.isi_out), r.isi);
        end
      end
    end
  end
  initial begin
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    run(128, 1, 1, 1);
    run(64, 1, 0, 1);
    run(64, 1, 2, 1);
    run(200, 1, 3, 0);
    run(20, 1, 3, 1);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    run(256, 1, 3, 3);
    run(30, 1, 3, 1);
    run(5, 0, 3, 1);
    run(130, 1, 3, 1);
    run(1500, 2, 3, 2);
    run(600, 2, 4, 2);
    run(300, 1, 2, 2);
    run(30, 1, 3, 1);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    run(140, 1, 3, 1);
    @(negedge clk);
    done = 1;
    chk("transfers_seen", int'(pops > 20), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
